// File: rtl/ft601_rx_fifo_reader.sv
// FT601 245-mode synchronous FIFO receive path: bursts words off the FT601 bus into a
// first-word-fall-through FIFO and presents them on an AXI4-Stream master.
module ft601_rx_fifo_reader #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MARGIN = 4
) (
    input  logic        USB_DATA_CLK,
    input  logic        rst,
    input  logic        USB_RXF_N,
    input  logic [31:0] USB_DATA_IN,
    input  logic [3:0]  USB_BE_IN,
    output logic        USB_OE_N,
    output logic        USB_RD_N,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        rx_overflow,
    output logic [31:0] rx_word_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StTurn,
        StRead,
        StDone
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_oe_n;
    logic           r_rd_n;

    logic [31:0]    r_mem_data [DEPTH];
    logic [3:0]     r_mem_be   [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_fill;
    logic           r_overflow;
    logic [31:0]    r_word_count;

    logic [CW-1:0]  w_free;
    logic           w_room;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_wr_en;
    logic           w_pop;

    assign w_free  = CW'(DEPTH) - r_fill;
    assign w_room  = (w_free >= CW'(MARGIN));
    assign w_full  = (r_fill == CW'(DEPTH));
    assign w_empty = (r_fill == '0);

    // Every cycle in READ with RXF_N low is a word the FT601 has already handed over.
    assign w_push  = (r_state == StRead) && !USB_RXF_N;
    assign w_wr_en = w_push && !w_full;
    assign w_pop   = !w_empty && m_axis_tready;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!USB_RXF_N && w_room) begin
                    w_state_next = StTurn;
                end
            end
            StTurn: begin
                w_state_next = USB_RXF_N ? StDone : StRead;
            end
            StRead: begin
                if (USB_RXF_N || !w_room) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Strobes are registered from the next state so they track the state register exactly.
    always_ff @(posedge USB_DATA_CLK) begin
        if (rst) begin
            r_state <= StIdle;
            r_oe_n  <= 1'b1;
            r_rd_n  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_oe_n  <= !((w_state_next == StTurn) || (w_state_next == StRead));
            r_rd_n  <= !(w_state_next == StRead);
        end
    end

    always_ff @(posedge USB_DATA_CLK) begin
        if (w_wr_en) begin
            r_mem_data[r_wr_ptr] <= USB_DATA_IN;
            r_mem_be[r_wr_ptr]   <= USB_BE_IN;
        end
    end

    always_ff @(posedge USB_DATA_CLK) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_wr_en, w_pop})
                2'b10:   r_fill <= r_fill + CW'(1);
                2'b01:   r_fill <= r_fill - CW'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge USB_DATA_CLK) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (w_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_word_count <= r_word_count + 32'd1;
            end
        end
    end

    assign USB_OE_N      = r_oe_n;
    assign USB_RD_N      = r_rd_n;
    assign m_axis_tdata  = r_mem_data[r_rd_ptr];
    assign m_axis_tkeep  = r_mem_be[r_rd_ptr];
    assign m_axis_tvalid = !w_empty;
    assign rx_overflow   = r_overflow;
    assign rx_word_count = r_word_count;

endmodule

// File: tb/tb_ft601_rx_fifo_reader.sv
// Bench for ft601_rx_fifo_reader: an FT601 host model feeds words and a queue scoreboard
// checks that every word reaches the stream in order.
module tb_ft601_rx_fifo_reader;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned MARGIN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        USB_RXF_N = 1'b1;
    logic [31:0] USB_DATA_IN = '0;
    logic [3:0]  USB_BE_IN = '0;
    logic        USB_OE_N;
    logic        USB_RD_N;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        rx_overflow;
    logic [31:0] rx_word_count;

    always #5 clk = ~clk;

    ft601_rx_fifo_reader #(
        .DEPTH  (DEPTH),
        .MARGIN (MARGIN)
    ) dut (
        .USB_DATA_CLK  (clk),
        .rst           (rst),
        .USB_RXF_N     (USB_RXF_N),
        .USB_DATA_IN   (USB_DATA_IN),
        .USB_BE_IN     (USB_BE_IN),
        .USB_OE_N      (USB_OE_N),
        .USB_RD_N      (USB_RD_N),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rx_overflow   (rx_overflow),
        .rx_word_count (rx_word_count)
    );

    int errors = 0;
    int checks = 0;

    logic [35:0] host_q[$];   // {be, data} the FT601 still has to send
    logic [35:0] exp_q[$];    // words accepted by the DUT, not yet popped
    int          pop_ticks[$];
    int          rxf_budget  = -1;   // cycles RXF_N may stay low; -1 = unlimited
    bit          rand_ready  = 1'b0;
    bit          rand_gap    = 1'b0;
    int          model_count = 0;
    int          tick_no     = 0;

    // One clock: resolve the transfer at the edge from pre-edge pins, then drive and check.
    task automatic tick();
        bit consumed;
        bit popped;
        consumed = !USB_RD_N && !USB_RXF_N && (host_q.size() != 0);
        popped   = m_axis_tvalid && m_axis_tready;
        @(posedge clk);
        #1;
        tick_no++;
        if (rst) begin
            exp_q.delete();
            model_count = 0;
        end else begin
            if (popped && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pop_ticks.push_back(tick_no);
            end
            if (consumed) begin
                exp_q.push_back(host_q[0]);
                model_count++;
            end
        end
        if (consumed) begin
            void'(host_q.pop_front());
        end
        if (host_q.size() != 0 && rxf_budget != 0 && !(rand_gap && $urandom_range(0, 3) == 0))
        begin
            USB_RXF_N = 1'b0;
            {USB_BE_IN, USB_DATA_IN} = host_q[0];
            if (rxf_budget > 0) rxf_budget--;
        end else begin
            USB_RXF_N   = 1'b1;
            USB_DATA_IN = $urandom;
            USB_BE_IN   = 4'($urandom);
        end
        if (rand_ready) m_axis_tready = ($urandom_range(0, 1) == 1);

        checks++;
        if (m_axis_tvalid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL sb_tvalid tick %0d: got %b want %b", tick_no, m_axis_tvalid,
                     exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if ({m_axis_tkeep, m_axis_tdata} !== exp_q[0]) begin
                errors++;
                $display("FAIL sb_word tick %0d: got %h want %h", tick_no,
                         {m_axis_tkeep, m_axis_tdata}, exp_q[0]);
            end
        end
        checks++;
        if (rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL sb_overflow tick %0d: got %b want 0", tick_no, rx_overflow);
        end
    endtask

    task automatic do_reset();
        host_q.delete();
        pop_ticks.delete();
        rxf_budget = -1;
        rand_ready = 1'b0;
        rand_gap   = 1'b0;
        m_axis_tready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int limit, input string name);
        int n = 0;
        while ((host_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (host_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: host %0d exp %0d left, want 0", name, host_q.size(),
                     exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({USB_OE_N, USB_RD_N, m_axis_tvalid, rx_overflow} !== 4'b1100 ||
            rx_word_count !== 32'd0) begin
            errors++;
            $display("FAIL reset: oe/rd/tvalid/ovf=%b cnt=%0d want 1100 cnt=0",
                     {USB_OE_N, USB_RD_N, m_axis_tvalid, rx_overflow}, rx_word_count);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        m_axis_tready = 1'b1;
        host_q.push_back({4'hF, 32'hDEADBEEF});
        tick();
        checks++;
        if (USB_OE_N !== 1'b1) begin
            errors++; $display("FAIL single_idle_oe: got %b want 1", USB_OE_N);
        end
        tick();
        checks++;
        if ({USB_OE_N, USB_RD_N} !== 2'b01) begin
            errors++; $display("FAIL single_turn: oe/rd got %b want 01", {USB_OE_N, USB_RD_N});
        end
        tick();
        checks++;
        if ({USB_OE_N, USB_RD_N, m_axis_tvalid} !== 3'b000) begin
            errors++;
            $display("FAIL single_read: oe/rd/tvalid got %b want 000",
                     {USB_OE_N, USB_RD_N, m_axis_tvalid});
        end
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hDEADBEEF || m_axis_tkeep !== 4'hF ||
            rx_word_count !== 32'd1) begin
            errors++;
            $display("FAIL single_out: v=%b d=%h k=%h cnt=%0d want 1 deadbeef f 1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, rx_word_count);
        end
        tick();
        checks++;
        if ({USB_OE_N, USB_RD_N, m_axis_tvalid} !== 3'b110) begin
            errors++;
            $display("FAIL single_done: oe/rd/tvalid got %b want 110",
                     {USB_OE_N, USB_RD_N, m_axis_tvalid});
        end
    endtask

    task automatic test_burst();
        int  n = 0;
        bit  pending = 1'b0;
        bit  done_rise = 1'b0;
        logic prev_rxf;
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 10; i++) host_q.push_back({4'hF, 32'(i)});
        while ((host_q.size() != 0 || exp_q.size() != 0 || pending) && n < 60) begin
            prev_rxf = USB_RXF_N;
            tick();
            n++;
            if (pending) begin
                pending = 1'b0;
                checks++;
                if ({USB_OE_N, USB_RD_N} !== 2'b11) begin
                    errors++;
                    $display("FAIL burst_release: oe/rd got %b want 11", {USB_OE_N, USB_RD_N});
                end
            end
            if (!done_rise && prev_rxf == 1'b0 && USB_RXF_N == 1'b1) begin
                done_rise = 1'b1;
                pending   = 1'b1;
            end
        end
        checks++;
        if (rx_word_count !== 32'd10 || pop_ticks.size() != 10) begin
            errors++;
            $display("FAIL burst_count: cnt=%0d pops=%0d want 10 10", rx_word_count,
                     pop_ticks.size());
        end else begin
            checks++;
            if (pop_ticks[9] - pop_ticks[0] != 9) begin
                errors++;
                $display("FAIL burst_gaps: span %0d want 9", pop_ticks[9] - pop_ticks[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          n = 0;
        bit          rd_seen = 1'b0;
        logic [31:0] stalled_count;
        bit          restarted = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) host_q.push_back({4'hF, 32'h100 + 32'(i)});
        while (!(rd_seen && USB_RD_N) && n < 80) begin
            tick();
            n++;
            if (!USB_RD_N) rd_seen = 1'b1;
        end
        checks++;
        if (rx_word_count < 32'(DEPTH - MARGIN) || rx_word_count > 32'(DEPTH - MARGIN + 2)) begin
            errors++;
            $display("FAIL bp_stop_fill: cnt=%0d want %0d..%0d", rx_word_count,
                     DEPTH - MARGIN, DEPTH - MARGIN + 2);
        end
        stalled_count = rx_word_count;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!USB_OE_N || !USB_RD_N) restarted = 1'b1;
        end
        checks++;
        if (restarted || rx_word_count !== stalled_count) begin
            errors++;
            $display("FAIL bp_hold: restarted=%b cnt=%0d want 0 %0d", restarted, rx_word_count,
                     stalled_count);
        end
        m_axis_tready = 1'b1;
        drain(200, "bp_drain");
        checks++;
        if (rx_word_count !== 32'd20 || pop_ticks.size() != 20) begin
            errors++;
            $display("FAIL bp_total: cnt=%0d pops=%0d want 20 20", rx_word_count,
                     pop_ticks.size());
        end
    endtask

    task automatic test_turn_abort();
        bit rd_low = 1'b0;
        do_reset();
        m_axis_tready = 1'b1;
        rxf_budget = 1;
        host_q.push_back({4'hF, 32'h55AA55AA});
        tick();
        tick();
        checks++;
        if ({USB_OE_N, USB_RD_N} !== 2'b01) begin
            errors++; $display("FAIL turn_enter: oe/rd got %b want 01", {USB_OE_N, USB_RD_N});
        end
        tick();
        checks++;
        if ({USB_OE_N, USB_RD_N} !== 2'b11) begin
            errors++; $display("FAIL turn_abort: oe/rd got %b want 11", {USB_OE_N, USB_RD_N});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!USB_RD_N) rd_low = 1'b1;
        end
        checks++;
        if (rd_low || rx_word_count !== 32'd0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL turn_nopush: rd_low=%b cnt=%0d v=%b want 0 0 0", rd_low,
                     rx_word_count, m_axis_tvalid);
        end
        host_q.delete();
        rxf_budget = -1;
    endtask

    task automatic test_partial();
        int n = 0;
        do_reset();
        host_q.push_back({4'h3, 32'h0000ABCD});
        while (!m_axis_tvalid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tkeep !== 4'h3 || m_axis_tdata !== 32'h0000ABCD)
        begin
            errors++;
            $display("FAIL partial: v=%b k=%h d=%h want 1 3 0000abcd", m_axis_tvalid,
                     m_axis_tkeep, m_axis_tdata);
        end
        m_axis_tready = 1'b1;
        drain(20, "partial_drain");
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        do_reset();
        for (int i = 0; i < 8; i++) host_q.push_back({4'hF, 32'h200 + 32'(i)});
        while (rx_word_count != 32'd3 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (rx_word_count !== 32'd3 || USB_RD_N !== 1'b0) begin
            errors++;
            $display("FAIL rmb_setup: cnt=%0d rd=%b want 3 0", rx_word_count, USB_RD_N);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({USB_OE_N, USB_RD_N, m_axis_tvalid} !== 3'b110 || rx_word_count !== 32'd0) begin
            errors++;
            $display("FAIL rmb_reset: oe/rd/tvalid=%b cnt=%0d want 110 0",
                     {USB_OE_N, USB_RD_N, m_axis_tvalid}, rx_word_count);
        end
        rst = 1'b0;
        m_axis_tready = 1'b1;
        drain(100, "rmb_drain");
        checks++;
        if (rx_word_count !== 32'(model_count) || model_count == 0) begin
            errors++;
            $display("FAIL rmb_resume: cnt=%0d want %0d (nonzero)", rx_word_count, model_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_ready = 1'b1;
        rand_gap   = 1'b1;
        for (int i = 0; i < 150; i++) host_q.push_back({4'($urandom), 32'($urandom)});
        drain(4000, "random_drain");
        checks++;
        if (rx_word_count !== 32'd150) begin
            errors++;
            $display("FAIL random_count: cnt=%0d want 150", rx_word_count);
        end
        rand_ready = 1'b0;
        rand_gap   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst();
        test_backpressure();
        test_turn_abort();
        test_partial();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
